pspi_master: RTL

PSPI_MASTER -- requirements
Module: pspi_master

---
 rtl/pspi_pkg.sv | 26 ++
 rtl/pspi_clk_div.sv | 40 ++++
 rtl/pspi_master.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pspi_pkg.sv
// Shared PSPI master types: FSM state encoding plus frame-length and select-width helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a. Define PSPI_PARITY_EN to append a parity bit to every frame.
package pspi_pkg;

    typedef logic [2:0] pspi_state_t;

    localparam pspi_state_t ST_IDLE  = 3'd0;
    localparam pspi_state_t ST_LEAD  = 3'd1;
    localparam pspi_state_t ST_XFER  = 3'd2;
    localparam pspi_state_t ST_TRAIL = 3'd3;
    localparam pspi_state_t ST_DONE  = 3'd4;

    function automatic int frame_len(input int data_w);
`ifdef PSPI_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

    function automatic int ss_width(input int num_ss);
        return (num_ss > 1) ? $clog2(num_ss) : 1;
    endfunction

endpackage

// File: rtl/pspi_clk_div.sv
// Half-period tick generator with sclk phase tracking and rise/fall strobes.
// Latency: tick every CLK_DIV cycles while run is high; strobes are combinational on tick.
// Backpressure: none; counter restarts whenever run drops.
module pspi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic xfer,
    output logic tick,
    output logic rise,
    output logic fall,
    output logic phase
);

    logic [7:0] cnt;

    assign tick = run && (cnt == 8'(CLK_DIV - 1));
    assign rise = tick && xfer && !phase;
    assign fall = tick && xfer && phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            if (!run || tick)
                cnt <= '0;
            else
                cnt <= cnt + 8'd1;
            // Phase only toggles during XFER so every period starts low.
            if (!xfer)
                phase <= 1'b0;
            else if (tick)
                phase <= ~phase;
        end
    end

endmodule

// File: rtl/pspi_master.sv
// Mode-0 SPI master: one frame per accepted start, optional trailing parity bit (PSPI_PARITY_EN).
// Latency: done pulses CLK_DIV*(2*FRAME_LEN+2)+1 cycles after the accept edge.
// Backpressure: start is ignored while busy, in the done cycle, or with an out-of-range ss_idx.
module pspi_master
    import pspi_pkg::*;
#(
    parameter int  DATA_W     = 8,
    parameter int  NUM_SS     = 4,
    parameter int  CLK_DIV    = 2,
    parameter int  PARITY_ODD = 0,
    localparam int SS_W       = ss_width(NUM_SS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SS_W-1:0]   ss_idx,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_err,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int FRAME_LEN = frame_len(DATA_W);

    pspi_state_t          state;
    logic [FRAME_LEN-1:0] tx_sr;
    logic [FRAME_LEN-1:0] rx_sr;
    logic [FRAME_LEN-1:0] tx_load;
    logic [DATA_W-1:0]    rx_word;
    logic                 rx_bad;
    logic [SS_W-1:0]      ss_sel;
    logic [NUM_SS-1:0]    sel_mask;
    logic [5:0]           bit_cnt;
    logic                 tick, rise, fall, phase, rise_d;
    logic                 active, accept;

    assign active   = (state == ST_LEAD) || (state == ST_XFER) || (state == ST_TRAIL);
    assign accept   = (state == ST_IDLE) && !busy && start && (32'(ss_idx) < NUM_SS);
    assign sel_mask = NUM_SS'(1) << ss_sel;

`ifdef PSPI_PARITY_EN
    assign tx_load = {tx_data, (^tx_data) ^ (PARITY_ODD != 0)};
    assign rx_word = rx_sr[FRAME_LEN-1:1];
    assign rx_bad  = rx_sr[0] != ((^rx_word) ^ (PARITY_ODD != 0));
`else
    assign tx_load = tx_data;
    assign rx_word = rx_sr;
    assign rx_bad  = 1'b0;
`endif

    pspi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (active),
        .xfer  (state == ST_XFER),
        .tick  (tick),
        .rise  (rise),
        .fall  (fall),
        .phase (phase)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            ss_sel  <= '0;
            bit_cnt <= '0;
            rise_d  <= 1'b0;
        end else begin
            // Pins are registered one cycle behind the FSM, so miso is sampled one cycle after the strobe,
            // exactly when the registered sclk rises.
            rise_d <= rise;
            if (rise_d)
                rx_sr <= {rx_sr[FRAME_LEN-2:0], miso};
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_LEAD;
                        tx_sr   <= tx_load;
                        ss_sel  <= ss_idx;
                        bit_cnt <= '0;
                    end
                end
                ST_LEAD: begin
                    if (tick)
                        state <= ST_XFER;
                end
                ST_XFER: begin
                    if (fall) begin
                        tx_sr <= {tx_sr[FRAME_LEN-2:0], 1'b0};
                        if (bit_cnt == 6'(FRAME_LEN - 1))
                            state <= ST_TRAIL;
                        else
                            bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                ST_TRAIL: begin
                    if (tick)
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            ss_n    <= '1;
            rx_data <= '0;
            rx_err  <= 1'b0;
        end else begin
            busy <= (state != ST_IDLE);
            done <= (state == ST_DONE);
            sclk <= (state == ST_XFER) && phase;
            mosi <= active && tx_sr[FRAME_LEN-1];
            ss_n <= active ? ~sel_mask : '1;
            if (state == ST_DONE) begin
                rx_data <= rx_word;
                rx_err  <= rx_bad;
            end
        end
    end

endmodule
